// File: rtl/cdc_pulse_pacer_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pulse_pacer_pkg
// Shared types and helpers for the source-side pulse pacer that feeds the
// toggle-based pulse synchronizer.
//   pacer_state_e : pacer FSM encoding (IDLE, FIRE, GAP)
//   gap_cnt_w()   : width of the gap down-counter for a given MIN_GAP
// -----------------------------------------------------------------------------
package cdc_pulse_pacer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } pacer_state_e;

  // The counter has to hold MIN_GAP-1; sizing for MIN_GAP+1 values keeps the
  // width at least one bit, including the MIN_GAP=1 case.
  function automatic int gap_cnt_w(input int min_gap);
    if (min_gap < 1) begin
      return 1;
    end else begin
      return $clog2(min_gap + 1);
    end
  endfunction

endpackage

// File: rtl/cdc_pulse_pacer_if.sv
// -----------------------------------------------------------------------------
// cdc_pulse_pacer_if
// Request/status bundle between local control logic (master) and the pacer
// (slave).
//   ev_i      : event request, one event per high cycle
//   clr_i     : synchronous flush of all pending events
//   ovf_clr_i : clears the sticky overflow flag
//   pulse_o   : paced single-cycle pulse toward the synchronizer
//   pend_o    : pending-event count
//   busy_o    : pacer active or events pending
//   ovf_o     : sticky "event lost to saturation" flag
// -----------------------------------------------------------------------------
interface cdc_pulse_pacer_if #(
  parameter int CNT_W = 4
);

  logic             ev_i;
  logic             clr_i;
  logic             ovf_clr_i;
  logic             pulse_o;
  logic [CNT_W-1:0] pend_o;
  logic             busy_o;
  logic             ovf_o;

  modport master (
    output ev_i, clr_i, ovf_clr_i,
    input  pulse_o, pend_o, busy_o, ovf_o
  );

  modport slave (
    input  ev_i, clr_i, ovf_clr_i,
    output pulse_o, pend_o, busy_o, ovf_o
  );

endinterface

// File: rtl/cdc_pulse_pacer.sv
// -----------------------------------------------------------------------------
// cdc_pulse_pacer
// Counts bursty single-cycle event requests and re-emits them as single-cycle
// pulses separated by at least MIN_GAP low cycles, so the downstream toggle /
// 2FF synchronizer never merges or drops events.
// Ports:
//   clk : source-domain clock
//   rst : asynchronous, active-high reset
//   bus : cdc_pulse_pacer_if.slave (ev_i, clr_i, ovf_clr_i in;
//         pulse_o, pend_o, busy_o, ovf_o out, all registered)
// Parameters:
//   CNT_W   : pending counter width, saturates at 2^CNT_W-1
//   MIN_GAP : minimum low cycles between two pulses (>= 1)
// -----------------------------------------------------------------------------
module cdc_pulse_pacer
  import cdc_pulse_pacer_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = 4
) (
  input  logic               clk,
  input  logic               rst,
  cdc_pulse_pacer_if.slave   bus
);

  localparam int               GW       = gap_cnt_w(MIN_GAP);
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_0   = {CNT_W{1'b0}};
  localparam logic [GW-1:0]    GAP_LOAD = GW'(MIN_GAP - 1);
  localparam logic [GW-1:0]    GAP_0    = {GW{1'b0}};

  if (MIN_GAP < 1 || CNT_W < 1) begin : g_param_err
    $error("cdc_pulse_pacer: MIN_GAP and CNT_W must both be >= 1");
  end

  pacer_state_e     state_r;
  logic [GW-1:0]    gap_r;
  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] pend_nx_s;
  logic             pulse_r;
  logic             busy_r;
  logic             ovf_r;
  logic             fire_s;
  logic             want_s;
  logic             drop_s;

  assign fire_s = (state_r == FIRE);
  // A flush vetoes any new pulse, even for an event arriving this cycle.
  assign want_s = ((pend_r != PEND_0) || bus.ev_i) && !bus.clr_i;

  // Pending counter next value: flush first, then +ev -fire with saturation.
  always_comb begin
    pend_nx_s = pend_r;
    drop_s    = 1'b0;
    if (bus.clr_i) begin
      pend_nx_s = PEND_0;
    end else if (bus.ev_i && !fire_s) begin
      if (pend_r == PEND_MAX) begin
        drop_s    = 1'b1;
        pend_nx_s = pend_r;
      end else begin
        pend_nx_s = pend_r + CNT_W'(1);
      end
    end else if (!bus.ev_i && fire_s) begin
      // FIRE is only entered with an event on the books; the guard is defensive.
      if (pend_r != PEND_0) begin
        pend_nx_s = pend_r - CNT_W'(1);
      end else begin
        pend_nx_s = pend_r;
      end
    end else begin
      pend_nx_s = pend_r;
    end
  end

  // Pending counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= PEND_0;
    end else begin
      pend_r <= pend_nx_s;
    end
  end

  // Sticky overflow: a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Pacer FSM with gap counter; pulse/busy are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      gap_r   <= GAP_0;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gap_r <= GAP_0;
          if (want_s) begin
            state_r <= FIRE;
            pulse_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
            busy_r  <= (pend_nx_s != PEND_0);
          end
        end
        FIRE: begin
          // The gap is always served, even after a flush, to protect spacing.
          state_r <= GAP;
          gap_r   <= GAP_LOAD;
          pulse_r <= 1'b0;
          busy_r  <= 1'b1;
        end
        GAP: begin
          if (gap_r != GAP_0) begin
            state_r <= GAP;
            gap_r   <= gap_r - GW'(1);
            pulse_r <= 1'b0;
            busy_r  <= 1'b1;
          end else if (want_s) begin
            state_r <= FIRE;
            gap_r   <= GAP_0;
            pulse_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            gap_r   <= GAP_0;
            pulse_r <= 1'b0;
            busy_r  <= (pend_nx_s != PEND_0);
          end
        end
        default: begin
          state_r <= IDLE;
          gap_r   <= GAP_0;
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_o = pulse_r;
  assign bus.pend_o  = pend_r;
  assign bus.busy_o  = busy_r;
  assign bus.ovf_o   = ovf_r;

endmodule

// File: tb/tb_cdc_pulse_pacer.sv
// -----------------------------------------------------------------------------
// tb_cdc_pulse_pacer
// Main instance: CNT_W=2, MIN_GAP=4, checked every cycle against a timing
// model (pulse allowed once MIN_GAP+1 cycles have passed since the last one)
// plus directed literal expectations. Second instance: CNT_W=4, MIN_GAP=10
// feeding a toggle/2FF synchronizer on a 3x slower clock, checked by counts.
// -----------------------------------------------------------------------------
module tb_cdc_pulse_pacer;

  localparam int MG   = 4;
  localparam int MAXP = 3;

  logic clk  = 1'b0;
  logic clk2 = 1'b0;
  logic rst  = 1'b1;

  always #5  clk  = ~clk;
  always #15 clk2 = ~clk2;

  cdc_pulse_pacer_if #(.CNT_W(2)) m_if ();
  cdc_pulse_pacer_if #(.CNT_W(4)) e_if ();

  cdc_pulse_pacer #(.CNT_W(2), .MIN_GAP(MG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  cdc_pulse_pacer #(.CNT_W(4), .MIN_GAP(10)) u_e2e (
    .clk (clk),
    .rst (rst),
    .bus (e_if.slave)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tot++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  int   m_pend;
  int   m_last;   // cycle index of the most recent pulse
  int   m_cyc;
  logic m_ovf;
  logic m_pulse, m_busy, m_fire_nx, m_drop;
  int   m_pend_nx;

  always_comb begin
    m_pulse   = (m_last == m_cyc);
    m_busy    = (m_pend != 0) || ((m_cyc - m_last) <= MG);
    m_fire_nx = ((m_pend != 0) || m_if.ev_i) && !m_if.clr_i && (m_cyc >= m_last + MG);
    m_drop    = !m_if.clr_i && m_if.ev_i && !m_pulse && (m_pend == MAXP);
    if (m_if.clr_i) begin
      m_pend_nx = 0;
    end else if (m_drop) begin
      m_pend_nx = MAXP;
    end else begin
      m_pend_nx = m_pend + int'(m_if.ev_i) - int'(m_pulse);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0;
      m_last <= -1000;
      m_cyc  <= 0;
      m_ovf  <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_pend <= m_pend_nx;
      if (m_fire_nx) m_last <= m_cyc + 1;
      if (m_drop) m_ovf <= 1'b1;
      else if (m_if.ovf_clr_i) m_ovf <= 1'b0;
    end
  end

  // Compare process: every cycle outside reset, on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp.pulse", int'(m_if.pulse_o), int'(m_pulse));
      chk("cmp.pend",  int'(m_if.pend_o),  m_pend);
      chk("cmp.busy",  int'(m_if.busy_o),  int'(m_busy));
      chk("cmp.ovf",   int'(m_if.ovf_o),   int'(m_ovf));
    end
  end

  // ---------------- end-to-end synchronizer path ----------------
  logic tog;
  logic s1, s2, s3;
  int   src_cnt, dst_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tog     <= 1'b0;
      src_cnt <= 0;
    end else begin
      tog <= tog ^ e_if.pulse_o;
      if (e_if.pulse_o) src_cnt <= src_cnt + 1;
    end
  end

  always @(posedge clk2 or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      dst_cnt <= 0;
    end else begin
      s1 <= tog; s2 <= s1; s3 <= s2;
      if (s2 ^ s3) dst_cnt <= dst_cnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic ev, input logic clr, input logic oclr);
    m_if.ev_i      = ev;
    m_if.clr_i     = clr;
    m_if.ovf_clr_i = oclr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npulse;
    int n_ev;
    int len;
    m_if.ev_i = 1'b0; m_if.clr_i = 1'b0; m_if.ovf_clr_i = 1'b0;
    e_if.ev_i = 1'b0; e_if.clr_i = 1'b0; e_if.ovf_clr_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset.pulse", int'(m_if.pulse_o), 0);
    chk("reset.pend",  int'(m_if.pend_o),  0);
    chk("reset.busy",  int'(m_if.busy_o),  0);
    chk("reset.ovf",   int'(m_if.ovf_o),   0);

    // Single event at cycle 5 -> pulse at 6, busy 6..10.
    for (int k = 0; k <= 12; k++) begin
      chk("single.pulse", int'(m_if.pulse_o), int'(k == 6));
      chk("single.busy",  int'(m_if.busy_o),  int'(k >= 6 && k <= 10));
      if (k == 6) chk("single.pend6", int'(m_if.pend_o), 1);
      if (k == 7) chk("single.pend7", int'(m_if.pend_o), 0);
      step(k == 5, 1'b0, 1'b0);
    end

    // Burst at cycles 0..2 -> pulses at 1, 6, 11; busy 1..15.
    for (int k = 0; k <= 17; k++) begin
      chk("burst.pulse", int'(m_if.pulse_o), int'(k == 1 || k == 6 || k == 11));
      chk("burst.busy",  int'(m_if.busy_o),  int'(k >= 1 && k <= 15));
      if (k == 3)  chk("burst.peak",  int'(m_if.pend_o), 2);
      if (k == 12) chk("burst.empty", int'(m_if.pend_o), 0);
      step(k <= 2, 1'b0, 1'b0);
    end

    // Saturation: ev held 0..7, drops at 4, 5, 7; clear with new drop at 7.
    npulse = 0;
    for (int k = 0; k <= 26; k++) begin
      npulse += int'(m_if.pulse_o);
      if (k == 4)  chk("sat.pend_max", int'(m_if.pend_o), MAXP);
      if (k == 4)  chk("sat.ovf_pre",  int'(m_if.ovf_o),  0);
      if (k == 5)  chk("sat.ovf_set",  int'(m_if.ovf_o),  1);
      if (k == 8)  chk("sat.ovf_setclr", int'(m_if.ovf_o), 1);
      if (k == 10) chk("sat.ovf_clr",  int'(m_if.ovf_o),  0);
      step(k <= 7, 1'b0, k == 7 || k == 9);
    end
    chk("sat.pulses", npulse, 5);

    // Flush during GAP with 3 pending: no further pulse, idle after the gap.
    for (int k = 0; k <= 15; k++) begin
      chk("flush.pulse", int'(m_if.pulse_o), int'(k == 1));
      chk("flush.busy",  int'(m_if.busy_o),  int'(k >= 1 && k <= 5));
      if (k == 4) chk("flush.pend3", int'(m_if.pend_o), 3);
      if (k == 5) chk("flush.pend0", int'(m_if.pend_o), 0);
      step(k <= 3, k == 4, 1'b0);
    end

    // Flush in FIRE: the pulse completes, the gap still runs.
    for (int k = 0; k <= 8; k++) begin
      chk("clrfire.pulse", int'(m_if.pulse_o), int'(k == 1));
      chk("clrfire.busy",  int'(m_if.busy_o),  int'(k >= 1 && k <= 5));
      if (k == 2) chk("clrfire.pend", int'(m_if.pend_o), 0);
      step(k <= 1, k == 1, 1'b0);
    end

    // Async reset mid-burst clears outputs without waiting for a clock edge.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.pulse", int'(m_if.pulse_o), 0);
    chk("arst.pend",  int'(m_if.pend_o),  0);
    chk("arst.busy",  int'(m_if.busy_o),  0);
    chk("arst.ovf",   int'(m_if.ovf_o),   0);
    m_if.ev_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // End-to-end: bursts spaced so pending never saturates.
    n_ev = 0;
    for (int b = 0; b < 20; b++) begin
      len = int'($urandom_range(4, 1));
      for (int i = 0; i < len; i++) begin
        e_if.ev_i = 1'b1;
        n_ev++;
        @(posedge clk);
        #1;
      end
      e_if.ev_i = 1'b0;
      repeat (60) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 600 && e_if.busy_o; i++) begin
      @(posedge clk);
      #1;
    end
    chk("e2e.drain", int'(e_if.busy_o), 0);
    repeat (20) @(posedge clk2);
    #1;
    chk("e2e.src_pulses", src_cnt, n_ev);
    chk("e2e.dst_pulses", dst_cnt, n_ev);
    chk("e2e.ovf", int'(e_if.ovf_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
